// File: rtl/program_loader_module_pkg.sv
// Shared loader definitions: default bus/address widths and FSM state encodings.
package program_loader_module_pkg;

  localparam int unsigned LOADER_ADDR_WIDTH = 8;
  localparam int unsigned LOADER_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } loader_state_e;

endpackage

// File: rtl/program_loader_module.sv
// Bus-master program loader: streams bytes into sequential RAM addresses (MAI then MI).
// Optional readback check after each write is enabled by defining LOADER_VERIFY_EN.
module program_loader_module
  import program_loader_module_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LOADER_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = LOADER_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] bus_o,
  output logic                  bus_oe_o,
  input  logic [DATA_WIDTH-1:0] bus_i,
  output logic                  mai_o,
  output logic                  mi_o,
  output logic                  mo_o,
  output logic                  hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  loader_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic                  err_d;

  logic [DATA_WIDTH-1:0] bus_d;
  logic                  bus_oe_d, mai_d, mi_d, mo_d;
  logic                  hold_d, busy_d, done_d, in_ready_d;

`ifndef LOADER_VERIFY_EN
  logic unused_bus;
  assign unused_bus = ^bus_i;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath updates and next-cycle (registered) outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    count_d = count_q;
    byte_d  = byte_q;
    err_d   = err_o;

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          addr_d  = base_i;
          len_d   = len_i;
          count_d = '0;
          err_d   = 1'b0;
          state_d = (len_i == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (in_valid_i && in_ready_o) begin
          byte_d  = in_data_i;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_DATA;
`ifdef LOADER_VERIFY_EN
      ST_DATA: state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (bus_i != byte_q) begin
          err_d = 1'b1;
        end
        state_d = ST_NEXT;
      end
`else
      ST_DATA: state_d = ST_NEXT;
`endif
      ST_NEXT: begin
        addr_d  = ADDR_WIDTH'(addr_q + 1'b1);
        count_d = CNT_WIDTH'(count_q + 1'b1);
        state_d = (count_d == len_q) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Hold/busy stay up for one extra cycle after DONE so the CPU restarts cleanly
    hold_d     = (state_d != ST_IDLE) || (state_q == ST_DONE);
    busy_d     = hold_d;
    in_ready_d = (state_d == ST_WAIT);
    mai_d      = (state_d == ST_ADDR);
    mi_d       = (state_d == ST_DATA);
    done_d     = (state_d == ST_DONE);
    bus_oe_d   = mai_d || mi_d;
`ifdef LOADER_VERIFY_EN
    mo_d       = (state_d == ST_VERIFY);
`else
    mo_d       = 1'b0;
`endif

    bus_d = '0;
    if (mai_d) begin
      bus_d = DATA_WIDTH'(addr_q);
    end else if (mi_d) begin
      bus_d = byte_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      byte_q     <= '0;
      err_o      <= 1'b0;
      bus_o      <= '0;
      bus_oe_o   <= 1'b0;
      mai_o      <= 1'b0;
      mi_o       <= 1'b0;
      mo_o       <= 1'b0;
      hold_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      in_ready_o <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      byte_q     <= byte_d;
      err_o      <= err_d;
      bus_o      <= bus_d;
      bus_oe_o   <= bus_oe_d;
      mai_o      <= mai_d;
      mi_o       <= mi_d;
      mo_o       <= mo_d;
      hold_o     <= hold_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      in_ready_o <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_program_loader_module.sv
// Directed bench for program_loader_module with a simple MAR/RAM bus model.
// Expectations adapt to LOADER_VERIFY_EN when the bench is built with it.
module tb_program_loader_module;

`ifdef LOADER_VERIFY_EN
  localparam logic VERIFY_ON = 1'b1;
`else
  localparam logic VERIFY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       load_i;
  logic [7:0] base_i;
  logic [8:0] len_i;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] bus_o;
  logic       bus_oe_o;
  logic [7:0] bus_i;
  logic       mai_o, mi_o, mo_o, hold_o, busy_o, done_o, err_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ram [0:255];
  logic [7:0] mar;
  logic [7:0] exp_data [0:7];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int mai_cnt, mo_cnt, done_cnt, ready_cnt, excl_viol;

  always #5 clk = ~clk;

  program_loader_module dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .base_i     (base_i),
    .len_i      (len_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .bus_o      (bus_o),
    .bus_oe_o   (bus_oe_o),
    .bus_i      (bus_i),
    .mai_o      (mai_o),
    .mi_o       (mi_o),
    .mo_o       (mo_o),
    .hold_o     (hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // RAM model; address 0x05 reads back corrupted
  assign bus_i = mo_o ? ((mar == 8'h05) ? (ram[mar] ^ 8'hFF) : ram[mar]) : 8'h00;

  always @(posedge clk) begin
    if (mai_o) mar <= bus_o;
    if (mi_o)  ram[mar] <= bus_o;
  end

  always @(negedge clk) begin
    if (mai_o) mai_cnt++;
    if (mo_o) mo_cnt++;
    if (done_o) done_cnt++;
    if (in_ready_o) ready_cnt++;
    if (mi_o) begin
      wr_addr_q.push_back(mar);
      wr_data_q.push_back(bus_o);
    end
    if ((32'(mai_o) + 32'(mi_o) + 32'(mo_o)) > 1 || (bus_oe_o && mo_o)) excl_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    mai_cnt = 0; mo_cnt = 0; done_cnt = 0; ready_cnt = 0;
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({in_ready_o, bus_oe_o, mai_o, mi_o, mo_o, hold_o, busy_o, done_o, err_o, bus_o});
  endfunction

  task automatic start_load(input logic [7:0] b, input logic [8:0] l);
    @(negedge clk);
    base_i = b; len_i = l; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
  endtask

  // Called on the done_o cycle: busy/hold linger one cycle, then drop
  task automatic finish_session(input string tag);
    chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd1);
    @(negedge clk);
    chk({tag, "_tail"}, 32'({busy_o, hold_o, done_o}), 32'b110);
    @(negedge clk);
    chk({tag, "_idle"}, 32'({busy_o, hold_o}), 32'b00);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] base, input int n);
    chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(n));
    chk({tag, "_nmai"}, 32'(mai_cnt), 32'(n));
    chk({tag, "_ndone"}, 32'(done_cnt), 32'd1);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      if (i < wr_addr_q.size()) begin
        chk($sformatf("%s_wa%0d", tag, i), 32'(wr_addr_q[i]), 32'(a));
        chk($sformatf("%s_wd%0d", tag, i), 32'(wr_data_q[i]), 32'(exp_data[i]));
      end
      chk($sformatf("%s_ram%0d", tag, i), 32'(ram[a]), 32'(exp_data[i]));
    end
  endtask

  task automatic stream(input string tag, input logic [7:0] base, input int n);
    start_load(base, 9'(n));
    for (int i = 0; i < n; i++) send_byte(tag, exp_data[i]);
    wait_done(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_mai, snap_wr, hold_low, n;
    rst = 1'b1; load_i = 1'b0; base_i = '0; len_i = '0;
    in_data_i = '0; in_valid_i = 1'b0; mar = '0; excl_viol = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    clr_mon();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", out_vec(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", out_vec(), 32'd0);

    // T1: base 0x00, three bytes, with latency checks on the first byte
    clr_mon();
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
    start_load(8'h00, 9'd3);
    chk("t1_session_up", 32'({busy_o, hold_o, in_ready_o}), 32'b111);
    send_byte("t1", 8'h11);
    chk("t1_addr_phase", 32'({mai_o, mi_o, bus_oe_o, bus_o}), {21'd0, 3'b101, 8'h00});
    @(negedge clk);
    chk("t1_data_phase", 32'({mai_o, mi_o, bus_oe_o, bus_o}), {21'd0, 3'b011, 8'h11});
    send_byte("t1", 8'h22);
    send_byte("t1", 8'h33);
    wait_done("t1");
    finish_session("t1");
    check_writes("t1", 8'h00, 3);

    // T2: zero-length session
    clr_mon();
    start_load(8'h40, 9'd0);
    chk("t2_done_cycle", 32'({done_o, busy_o, hold_o, in_ready_o}), 32'b1110);
    finish_session("t2");
    chk("t2_no_mai", 32'(mai_cnt), 32'd0);
    chk("t2_no_mi", 32'(wr_addr_q.size()), 32'd0);
    chk("t2_no_ready", 32'(ready_cnt), 32'd0);
    chk("t2_one_done", 32'(done_cnt), 32'd1);

    // T3: address wrap FE, FF, 00, 01
    clr_mon();
    exp_data[0] = 8'hA1; exp_data[1] = 8'hA2; exp_data[2] = 8'hA3; exp_data[3] = 8'hA4;
    stream("t3", 8'hFE, 4);
    finish_session("t3");
    check_writes("t3", 8'hFE, 4);

    // T4: 10-cycle stream stall after the first byte
    clr_mon();
    exp_data[0] = 8'hC1; exp_data[1] = 8'hC2; exp_data[2] = 8'hC3;
    start_load(8'h20, 9'd3);
    send_byte("t4", 8'hC1);
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap_mai = mai_cnt; snap_wr = wr_addr_q.size(); hold_low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!hold_o || !in_ready_o) hold_low++;
    end
    chk("t4_wait_held", 32'(hold_low), 32'd0);
    chk("t4_no_strobes", 32'((mai_cnt - snap_mai) + (wr_addr_q.size() - snap_wr)), 32'd0);
    send_byte("t4", 8'hC2);
    send_byte("t4", 8'hC3);
    wait_done("t4");
    finish_session("t4");
    check_writes("t4", 8'h20, 3);

    // T5: reset asserted during DATA, then a clean session
    start_load(8'h30, 9'd2);
    send_byte("t5", 8'h5A);
    @(negedge clk);
    chk("t5_in_data", 32'(mi_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_async_rst", out_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr_mon();
    exp_data[0] = 8'h77;
    stream("t5b", 8'h50, 1);
    finish_session("t5b");
    check_writes("t5b", 8'h50, 1);
    chk("t5b_err", 32'(err_o), 32'd0);

    // T6: corrupted readback at 0x05
    clr_mon();
    exp_data[0] = 8'h10; exp_data[1] = 8'h20; exp_data[2] = 8'h30;
    stream("t6", 8'h04, 3);
    chk("t6_err_at_done", 32'(err_o), 32'(VERIFY_ON));
    finish_session("t6");
    chk("t6_err_sticky", 32'(err_o), 32'(VERIFY_ON));
    chk("t6_mo_count", 32'(mo_cnt), VERIFY_ON ? 32'd3 : 32'd0);
    start_load(8'h60, 9'd0);
    chk("t6_err_cleared", 32'(err_o), 32'd0);
    finish_session("t6b");

    chk("strobe_exclusive", 32'(excl_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
